// File: rtl/rr_flow_pkg.sv
// Shared types, defaults and helpers for the record/replay logging flow controller.
package rr_flow_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      DRAIN  = 2'd2,
      FLUSH  = 2'd3
   } rr_flow_state_t;

   localparam int unsigned DEF_LOGB_CHANNEL_CNT = 4;
   localparam int unsigned DEF_LOGE_CHANNEL_CNT = 4;
   localparam int unsigned DEF_FILL_W           = 10;
   localparam int unsigned DEF_HI_THRESH        = 960;
   localparam int unsigned DEF_LO_THRESH        = 768;
   localparam int unsigned DEF_HYST             = 32;
   localparam int unsigned DEF_OUTST_W          = 16;
   localparam int unsigned STAT_W               = 32;
   localparam int unsigned PC_W                 = 6;

   // Number of set bits in a strobe vector of up to 32 channels.
   function automatic logic [PC_W-1:0] popcount(input logic [31:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < 32; i++) c = c + PC_W'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/rr_logging_flow_ctrl_if.sv
// Logging-bus control interface; define RR_LOG_FLOW_STATS_EN to add the statistics outputs.
interface rr_logging_flow_ctrl_if
   import rr_flow_pkg::*;
#(
   parameter int unsigned LOGB_CHANNEL_CNT = DEF_LOGB_CHANNEL_CNT,
   parameter int unsigned LOGE_CHANNEL_CNT = DEF_LOGE_CHANNEL_CNT,
   parameter int unsigned FILL_W           = DEF_FILL_W,
   parameter int unsigned OUTST_W          = DEF_OUTST_W
);
   logic                        record_start;
   logic                        record_stop;
   logic [LOGB_CHANNEL_CNT-1:0] logb_valid;
   logic [LOGE_CHANNEL_CNT-1:0] loge_valid;
   logic [FILL_W-1:0]           fifo_fill;
   logic                        flush_done;
   logic                        log_enable;
   logic                        logb_almful_hi;
   logic                        logb_almful_lo;
   logic                        flush_req;
   logic                        busy;
   logic [OUTST_W-1:0]          outstanding;
   logic                        err_underflow;
`ifdef RR_LOG_FLOW_STATS_EN
   logic [STAT_W-1:0]           stat_logb_cnt;
   logic [STAT_W-1:0]           stat_loge_cnt;
   logic [STAT_W-1:0]           stat_stall_cycles;
`endif

   modport master (
      output record_start, record_stop, logb_valid, loge_valid, fifo_fill, flush_done,
      input  log_enable, logb_almful_hi, logb_almful_lo, flush_req, busy, outstanding,
             err_underflow
`ifdef RR_LOG_FLOW_STATS_EN
      , input stat_logb_cnt, stat_loge_cnt, stat_stall_cycles
`endif
   );

   modport slave (
      input  record_start, record_stop, logb_valid, loge_valid, fifo_fill, flush_done,
      output log_enable, logb_almful_hi, logb_almful_lo, flush_req, busy, outstanding,
             err_underflow
`ifdef RR_LOG_FLOW_STATS_EN
      , output stat_logb_cnt, stat_loge_cnt, stat_stall_cycles
`endif
   );

endinterface

// File: rtl/rr_hyst_flag.sv
// Fill-level flag with hysteresis: sets at THRESH, clears below THRESH-HYST.
module rr_hyst_flag #(
   parameter int unsigned W      = 10,
   parameter int unsigned THRESH = 960,
   parameter int unsigned HYST   = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] fill,
   output logic         flag
);
   localparam int unsigned CLR_LVL = THRESH - HYST;

   logic        flag_q, flag_d;
   logic [31:0] fill_ext;

   assign fill_ext = 32'(fill);

   always_comb begin
      flag_d = flag_q;
      if (fill_ext >= THRESH)       flag_d = 1'b1;
      else if (fill_ext < CLR_LVL)  flag_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flag_q <= 1'b0;
      else        flag_q <= flag_d;
   end

   assign flag = flag_q;

endmodule

// File: rtl/rr_logging_flow_ctrl.sv
// Record/replay logging-bus controller: session FSM, outstanding tracking, back-pressure.
// Optional statistics counters are compiled in with RR_LOG_FLOW_STATS_EN.
module rr_logging_flow_ctrl
   import rr_flow_pkg::*;
#(
   parameter int unsigned LOGB_CHANNEL_CNT = DEF_LOGB_CHANNEL_CNT,
   parameter int unsigned LOGE_CHANNEL_CNT = DEF_LOGE_CHANNEL_CNT,
   parameter int unsigned FILL_W           = DEF_FILL_W,
   parameter int unsigned HI_THRESH        = DEF_HI_THRESH,
   parameter int unsigned LO_THRESH        = DEF_LO_THRESH,
   parameter int unsigned HYST             = DEF_HYST,
   parameter int unsigned OUTST_W          = DEF_OUTST_W
) (
   input logic                  clk,
   input logic                  rst_n,
   rr_logging_flow_ctrl_if.slave bus
);
   localparam int unsigned SUM_W = OUTST_W + 2;

   rr_flow_state_t              state_q, state_d;
   logic                        log_enable_q, log_enable_d;
   logic                        flush_req_q, flush_req_d;
   logic                        busy_q, busy_d;
   logic                        err_underflow_q, err_underflow_d;
   logic [OUTST_W-1:0]          outstanding_q, outstanding_d;
   logic                        start_sess;
   logic [SUM_W-1:0]            sum_up, sum_diff;
   logic [LOGB_CHANNEL_CNT-1:0] logb_v;
   logic [LOGE_CHANNEL_CNT-1:0] loge_v;
   logic [PC_W-1:0]             pc_b, pc_e;
   logic                        almful_hi, almful_lo;
   logic [FILL_W-1:0]           fill;

   assign logb_v = bus.logb_valid;
   assign loge_v = bus.loge_valid;
   assign fill   = bus.fifo_fill;
   assign pc_b   = popcount(32'(logb_v));
   assign pc_e   = popcount(32'(loge_v));

   // Session FSM and outstanding counter; strobes count only while log_enable is set.
   always_comb begin
      state_d         = state_q;
      outstanding_d   = outstanding_q;
      err_underflow_d = err_underflow_q;
      start_sess      = 1'b0;
      sum_up          = '0;
      sum_diff        = '0;

      case (state_q)
         IDLE:    if (bus.record_start) begin
                     state_d    = RECORD;
                     start_sess = 1'b1;
                  end
         RECORD:  if (bus.record_stop) state_d = DRAIN;
         DRAIN:   if (outstanding_q == '0 && !(|logb_v) && !(|loge_v)) state_d = FLUSH;
         FLUSH:   if (bus.flush_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (start_sess) begin
         outstanding_d   = '0;
         err_underflow_d = 1'b0;
      end else if (log_enable_q) begin
         sum_up   = SUM_W'(outstanding_q) + SUM_W'(pc_b);
         sum_diff = sum_up - SUM_W'(pc_e);
         if (sum_up < SUM_W'(pc_e)) begin
            outstanding_d   = '0;
            err_underflow_d = 1'b1;
         end else if (sum_diff[SUM_W-1:OUTST_W] != '0) begin
            outstanding_d = '1;
         end else begin
            outstanding_d = sum_diff[OUTST_W-1:0];
         end
      end

      log_enable_d = (state_d == RECORD) || (state_d == DRAIN);
      flush_req_d  = (state_d == FLUSH);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         log_enable_q    <= 1'b0;
         flush_req_q     <= 1'b0;
         busy_q          <= 1'b0;
         err_underflow_q <= 1'b0;
         outstanding_q   <= '0;
      end else begin
         state_q         <= state_d;
         log_enable_q    <= log_enable_d;
         flush_req_q     <= flush_req_d;
         busy_q          <= busy_d;
         err_underflow_q <= err_underflow_d;
         outstanding_q   <= outstanding_d;
      end
   end

   rr_hyst_flag #(.W(FILL_W), .THRESH(HI_THRESH), .HYST(HYST)) u_hyst_hi (
      .clk(clk), .rst_n(rst_n), .fill(fill), .flag(almful_hi)
   );

   rr_hyst_flag #(.W(FILL_W), .THRESH(LO_THRESH), .HYST(HYST)) u_hyst_lo (
      .clk(clk), .rst_n(rst_n), .fill(fill), .flag(almful_lo)
   );

   assign bus.log_enable     = log_enable_q;
   assign bus.flush_req      = flush_req_q;
   assign bus.busy           = busy_q;
   assign bus.outstanding    = outstanding_q;
   assign bus.err_underflow  = err_underflow_q;
   assign bus.logb_almful_hi = almful_hi;
   assign bus.logb_almful_lo = almful_lo;

`ifdef RR_LOG_FLOW_STATS_EN
   logic [STAT_W-1:0] stat_logb_q, stat_logb_d;
   logic [STAT_W-1:0] stat_loge_q, stat_loge_d;
   logic [STAT_W-1:0] stat_stall_q, stat_stall_d;

   // Beat and stall counters; wrap naturally, cleared when a session starts.
   always_comb begin
      stat_logb_d  = stat_logb_q;
      stat_loge_d  = stat_loge_q;
      stat_stall_d = stat_stall_q;
      if (start_sess) begin
         stat_logb_d  = '0;
         stat_loge_d  = '0;
         stat_stall_d = '0;
      end else if (log_enable_q) begin
         stat_logb_d = stat_logb_q + STAT_W'(pc_b);
         stat_loge_d = stat_loge_q + STAT_W'(pc_e);
         if (almful_hi) stat_stall_d = stat_stall_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_logb_q  <= '0;
         stat_loge_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_logb_q  <= stat_logb_d;
         stat_loge_q  <= stat_loge_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign bus.stat_logb_cnt     = stat_logb_q;
   assign bus.stat_loge_cnt     = stat_loge_q;
   assign bus.stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rr_logging_flow_ctrl.sv
// Self-checking bench for rr_logging_flow_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model (RR_LOG_FLOW_STATS_EN optional).
module tb_rr_logging_flow_ctrl;

   localparam int NB = 4;
   localparam int NE = 4;
   localparam int FW = 10;
   localparam int OW = 16;
   localparam int HI_T = 960;
   localparam int LO_T = 768;
   localparam int HY = 32;
   localparam int OMAX = 65535;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rr_logging_flow_ctrl_if #(.LOGB_CHANNEL_CNT(NB), .LOGE_CHANNEL_CNT(NE),
                             .FILL_W(FW), .OUTST_W(OW)) bus ();

   rr_logging_flow_ctrl #(.LOGB_CHANNEL_CNT(NB), .LOGE_CHANNEL_CNT(NE), .FILL_W(FW),
                          .HI_THRESH(HI_T), .LO_THRESH(LO_T), .HYST(HY), .OUTST_W(OW))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int cur_fill = 0;

   // Model: session phase 0=idle 1=record 2=drain 3=flush
   int          m_phase = 0;
   int          m_out = 0;
   bit          m_err = 0, m_hi = 0, m_lo = 0;
   logic [31:0] m_sb = 0, m_se = 0, m_ss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit hyst(input bit cur, input int f, input int th, input int hy);
      if (f >= th) return 1'b1;
      if (f < th - hy) return 1'b0;
      return cur;
   endfunction

   // Behavioural reference, advanced on every active edge.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_out = 0; m_err = 0; m_hi = 0; m_lo = 0;
            m_sb = 0; m_se = 0; m_ss = 0;
         end else begin
            int pb, pe, v, nxt;
            pb  = $countones(bus.logb_valid);
            pe  = $countones(bus.loge_valid);
            nxt = m_phase;
            case (m_phase)
               0: if (bus.record_start) nxt = 1;
               1: if (bus.record_stop) nxt = 2;
               2: if (m_out == 0 && pb == 0 && pe == 0) nxt = 3;
               default: if (bus.flush_done) nxt = 0;
            endcase
            if (m_phase == 0 && nxt == 1) begin
               m_out = 0; m_err = 0; m_sb = 0; m_se = 0; m_ss = 0;
            end else if (m_phase == 1 || m_phase == 2) begin
               if (m_hi) m_ss = m_ss + 1;
               m_sb = m_sb + 32'(pb);
               m_se = m_se + 32'(pe);
               v = m_out + pb - pe;
               if (v < 0) begin v = 0; m_err = 1; end
               if (v > OMAX) v = OMAX;
               m_out = v;
            end
            m_phase = nxt;
            m_hi = hyst(m_hi, int'(bus.fifo_fill), HI_T, HY);
            m_lo = hyst(m_lo, int'(bus.fifo_fill), LO_T, HY);
         end
      end
   end

   // Compare DUT against model on the inactive edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en && rst_n) begin
            chk("log_enable", 32'(bus.log_enable), 32'(m_phase == 1 || m_phase == 2));
            chk("flush_req", 32'(bus.flush_req), 32'(m_phase == 3));
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("outstanding", 32'(bus.outstanding), 32'(m_out));
            chk("err_underflow", 32'(bus.err_underflow), 32'(m_err));
            chk("almful_hi", 32'(bus.logb_almful_hi), 32'(m_hi));
            chk("almful_lo", 32'(bus.logb_almful_lo), 32'(m_lo));
            chk("hi_implies_lo", 32'(bus.logb_almful_hi & ~bus.logb_almful_lo), 32'd0);
`ifdef RR_LOG_FLOW_STATS_EN
            chk("stat_logb_cnt", bus.stat_logb_cnt, m_sb);
            chk("stat_loge_cnt", bus.stat_loge_cnt, m_se);
            chk("stat_stall_cycles", bus.stat_stall_cycles, m_ss);
`endif
         end
      end
   end

   // Drive one cycle of inputs at the falling edge; return just after the next rising edge.
   task automatic cyc(input bit st = 0, input bit sp = 0, input logic [3:0] b = 4'd0,
                      input logic [3:0] e = 4'd0, input int f = -1, input bit fd = 0);
      @(negedge clk);
      if (f >= 0) cur_fill = f;
      bus.record_start = st;
      bus.record_stop  = sp;
      bus.logb_valid   = b;
      bus.loge_valid   = e;
      bus.fifo_fill    = FW'(cur_fill);
      bus.flush_done   = fd;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_log_enable"}, 32'(bus.log_enable), 32'd0);
      chk({tag, "_flush_req"}, 32'(bus.flush_req), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_outstanding"}, 32'(bus.outstanding), 32'd0);
      chk({tag, "_err"}, 32'(bus.err_underflow), 32'd0);
      chk({tag, "_hi"}, 32'(bus.logb_almful_hi), 32'd0);
      chk({tag, "_lo"}, 32'(bus.logb_almful_lo), 32'd0);
   endtask

   initial begin
      bus.record_start = 0; bus.record_stop = 0; bus.logb_valid = '0;
      bus.loge_valid = '0; bus.fifo_fill = '0; bus.flush_done = 0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Basic session: three opens, three closes, stop, flush.
      cyc(.st(1));
      chk("t1_le_after_start", 32'(bus.log_enable), 32'd1);
      repeat (3) cyc(.b(4'b0001));
      chk("t1_out3", 32'(bus.outstanding), 32'd3);
      repeat (3) cyc(.e(4'b0100));
      chk("t1_out0", 32'(bus.outstanding), 32'd0);
      cyc(.sp(1));
      chk("t1_drain_le", 32'(bus.log_enable), 32'd1);
      cyc();
      chk("t1_flush_req", 32'(bus.flush_req), 32'd1);
      chk("t1_flush_le", 32'(bus.log_enable), 32'd0);
      repeat (2) cyc();
      chk("t1_flush_hold", 32'(bus.flush_req), 32'd1);
      cyc(.fd(1));
      chk("t1_idle_busy", 32'(bus.busy), 32'd0);

      // Stop with two outstanding; stays in DRAIN until closes land.
      cyc(.st(1));
      cyc(.b(4'b0011));
      chk("t2_out2", 32'(bus.outstanding), 32'd2);
      cyc(.sp(1));
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_no_flush", 32'(bus.flush_req), 32'd0);
      end
      cyc(.e(4'b1001));
      chk("t2_out0_still_drain", 32'(bus.flush_req), 32'd0);
      cyc();
      chk("t2_flush", 32'(bus.flush_req), 32'd1);
      cyc(.fd(1));

      // Fill ramp up and down through both hysteresis windows.
      for (int f = 0; f <= 1000; f += 8) begin
         cyc(.f(f));
         if (f == 952) chk("t3_hi_below", 32'(bus.logb_almful_hi), 32'd0);
         if (f == 952) chk("t3_lo_set", 32'(bus.logb_almful_lo), 32'd1);
         if (f == 960) chk("t3_hi_set", 32'(bus.logb_almful_hi), 32'd1);
      end
      for (int f = 996; f >= 700; f -= 4) begin
         cyc(.f(f));
         if (f == 928) chk("t3_hi_hold", 32'(bus.logb_almful_hi), 32'd1);
         if (f == 924) chk("t3_hi_clr", 32'(bus.logb_almful_hi), 32'd0);
         if (f == 736) chk("t3_lo_hold", 32'(bus.logb_almful_lo), 32'd1);
         if (f == 732) chk("t3_lo_clr", 32'(bus.logb_almful_lo), 32'd0);
      end
      cyc(.f(0));

`ifdef RR_LOG_FLOW_STATS_EN
      // Statistics: ten opens, five enabled cycles under almful_hi.
      cyc(.st(1));
      repeat (6) cyc(.b(4'b0001));
      cyc(.f(1000));
      repeat (4) cyc(.b(4'b0010), .f(1000));
      cyc(.f(0));
      chk("s_logb10", bus.stat_logb_cnt, 32'd10);
      chk("s_stall5", bus.stat_stall_cycles, 32'd5);
      cyc(.sp(1));
      repeat (2) cyc(.e(4'b1111));
      cyc(.e(4'b0011));
      chk("s_loge10", bus.stat_loge_cnt, 32'd10);
      cyc();
      cyc(.fd(1));
      cyc(.st(1));
      chk("s_clr_logb", bus.stat_logb_cnt, 32'd0);
      chk("s_clr_stall", bus.stat_stall_cycles, 32'd0);
      cyc(.sp(1));
      cyc();
      cyc(.fd(1));
`endif

      // Underflow is clamped, sticky, and cleared only by a new start.
      cyc(.st(1));
      cyc(.e(4'b0001));
      chk("t4_out_clamp", 32'(bus.outstanding), 32'd0);
      chk("t4_err_set", 32'(bus.err_underflow), 32'd1);
      cyc(.sp(1));
      cyc();
      cyc(.fd(1));
      chk("t4_err_idle", 32'(bus.err_underflow), 32'd1);
      cyc(.st(1));
      chk("t4_err_clr", 32'(bus.err_underflow), 32'd0);

      // start+stop together: stop wins in RECORD, start wins in IDLE.
      cyc(.st(1), .sp(1));
      cyc();
      chk("t5_rec_pair_drain", 32'(bus.flush_req), 32'd1);
      cyc(.fd(1));
      cyc(.st(1), .sp(1));
      chk("t5_idle_pair_le", 32'(bus.log_enable), 32'd1);
      cyc();
      chk("t5_idle_pair_rec", 32'(bus.flush_req), 32'd0);
      cyc(.b(4'b0001), .f(1000));
      cyc(.sp(1));
      cyc();
      chk("t5_drain_busy", 32'(bus.busy), 32'd1);
      chk("t5_drain_hi", 32'(bus.logb_almful_hi), 32'd1);
      rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      cur_fill = 0;
      bus.fifo_fill = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int d;
         logic [3:0] b, e;
         b = 4'($urandom & $urandom);
         e = 4'($urandom & $urandom);
         if ((i / 60) % 3 == 0) begin b = '0; if ($urandom_range(0, 1) == 0) e = '0; end
         d = int'($urandom_range(0, 80)) - 40;
         cur_fill = cur_fill + d;
         if ($urandom_range(0, 99) == 0) cur_fill = int'($urandom_range(0, 1023));
         if (cur_fill < 0) cur_fill = 0;
         if (cur_fill > 1023) cur_fill = 1023;
         cyc(.st($urandom_range(0, 19) == 0), .sp($urandom_range(0, 19) == 0),
             .b(b), .e(e), .f(cur_fill), .fd($urandom_range(0, 7) == 0));
      end

      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
